fetch_stage: RTL and testbench

Instruction-fetch stage of the RV32 pipeline. Owns the program counter and drives it to the combinational instruction memory. Captures the returned word into the IF/ID pipeline register. Handles stall, branch/jump redirect with flush, misaligned-target detection and a fetch counter. Sits directly upstream of the instruction memory; the decode stage consumes its IF/ID outputs.

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 47 ++++
 tb/tb_fetch_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: control, imem and IF/ID signals between fetch stage and its neighbours
interface fetch_stage_if #(parameter int CNT_W = 16);
  logic             stall;
  logic             redirect;
  logic [31:0]      redirect_target;
  logic [31:0]      instr_in;
  logic [31:0]      pc_out;
  logic [31:0]      if_id_pc;
  logic [31:0]      if_id_pc_plus4;
  logic [31:0]      if_id_instr;
  logic             if_id_valid;
  logic             misaligned;
  logic [CNT_W-1:0] fetch_count;
  modport master (
    input  stall, redirect, redirect_target, instr_in,
    output pc_out, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid, misaligned, fetch_count
  );
  modport slave (
    output stall, redirect, redirect_target, instr_in,
    input  pc_out, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid, misaligned, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32 PC owner and IF/ID register with stall, redirect/flush, misalign flag and fetch counter
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          CNT_W     = 16
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);
  logic [31:0]      r_pc, r_if_pc, r_if_pc4, r_if_instr;
  logic             r_if_valid, r_misaligned;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      w_pc_plus4;
  assign w_pc_plus4 = r_pc + 32'd4;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_if_pc      <= '0;
      r_if_pc4     <= 32'd4;
      r_if_instr   <= NOP_INSTR;
      r_if_valid   <= 1'b0;
      r_misaligned <= 1'b0;
      r_count      <= '0;
    end else if (bus.redirect) begin
      // flush keeps the bubble's pc fields; only instr/valid mark it as a bubble
      r_pc         <= {bus.redirect_target[31:2], 2'b00};
      r_if_instr   <= NOP_INSTR;
      r_if_valid   <= 1'b0;
      r_misaligned <= r_misaligned | (|bus.redirect_target[1:0]);
    end else if (!bus.stall) begin
      r_pc       <= w_pc_plus4;
      r_if_pc    <= r_pc;
      r_if_pc4   <= w_pc_plus4;
      r_if_instr <= bus.instr_in;
      r_if_valid <= 1'b1;
      r_count    <= &r_count ? r_count : r_count + 1'b1;
    end
  end
  assign bus.pc_out         = r_pc;
  assign bus.if_id_pc       = r_if_pc;
  assign bus.if_id_pc_plus4 = r_if_pc4;
  assign bus.if_id_instr    = r_if_instr;
  assign bus.if_id_valid    = r_if_valid;
  assign bus.misaligned     = r_misaligned;
  assign bus.fetch_count    = r_count;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan steps then random stall/redirect/reset traffic against a cycle model
module tb_fetch_stage;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  fetch_stage_if #(.CNT_W(CW)) bus ();
  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h13), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hA0000000 | (a >> 2);
  endfunction
  assign bus.instr_in = mem(bus.pc_out);
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr;
  logic        m_valid, m_mis;
  int          m_cnt;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] tgt);
    @(negedge clk);
    reset = r;
    bus.stall = s;
    bus.redirect = rd;
    bus.redirect_target = tgt;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h4; m_instr = 32'h13;
      m_valid = 1'b0; m_mis = 1'b0; m_cnt = 0;
    end else if (rd) begin
      m_pc = tgt & ~32'h3;
      m_instr = 32'h13;
      m_valid = 1'b0;
      if (tgt % 4 != 0) m_mis = 1'b1;
    end else if (!s) begin
      m_ifpc = m_pc;
      m_ifpc4 = m_pc + 32'd4;
      m_instr = mem(m_pc);
      m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      m_cnt = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
    end
    #1;
    chk("pc_out", bus.pc_out, m_pc);
    chk("if_id_pc", bus.if_id_pc, m_ifpc);
    chk("if_id_pc_plus4", bus.if_id_pc_plus4, m_ifpc4);
    chk("if_id_instr", bus.if_id_instr, m_instr);
    chk("if_id_valid", {31'b0, bus.if_id_valid}, {31'b0, m_valid});
    chk("misaligned", {31'b0, bus.misaligned}, {31'b0, m_mis});
    chk("fetch_count", {{(32-CW){1'b0}}, bus.fetch_count}, m_cnt);
  endtask
  initial begin
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = '0;
    // 1: reset then straight-line fetch
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_plus4", bus.if_id_pc_plus4, 32'h4);
    chk("rst_instr", bus.if_id_instr, 32'h13);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0);
      chk("seq_pc", bus.pc_out, 32'(4 * (i + 1)));
      chk("seq_instr", bus.if_id_instr, 32'hA0000000 + 32'(i));
      chk("seq_valid", {31'b0, bus.if_id_valid}, 32'h1);
    end
    chk("seq_count", {28'b0, bus.fetch_count}, 32'h4);
    // 2: stall at PC=8
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    chk("stall_pc", bus.pc_out, 32'h8);
    chk("stall_instr", bus.if_id_instr, 32'hA0000001);
    chk("stall_ifpc", bus.if_id_pc, 32'h4);
    chk("stall_count", {28'b0, bus.fetch_count}, 32'h2);
    cyc(0, 0, 0, 0);
    chk("unstall_instr", bus.if_id_instr, 32'hA0000002);
    chk("unstall_ifpc", bus.if_id_pc, 32'h8);
    // 3: redirect beats stall
    cyc(0, 1, 1, 32'h40);
    chk("redir_pc", bus.pc_out, 32'h40);
    chk("redir_instr", bus.if_id_instr, 32'h13);
    chk("redir_valid", {31'b0, bus.if_id_valid}, 32'h0);
    cyc(0, 0, 0, 0);
    chk("post_redir_instr", bus.if_id_instr, 32'hA0000010);
    chk("post_redir_ifpc", bus.if_id_pc, 32'h40);
    // 4: misaligned is sticky until reset
    cyc(0, 0, 1, 32'h47);
    chk("mis_pc", bus.pc_out, 32'h44);
    chk("mis_set", {31'b0, bus.misaligned}, 32'h1);
    cyc(0, 0, 1, 32'h80);
    cyc(0, 0, 1, 32'h80);
    chk("mis_sticky", {31'b0, bus.misaligned}, 32'h1);
    cyc(1, 0, 0, 0);
    chk("mis_clear", {31'b0, bus.misaligned}, 32'h0);
    // 5: PC wrap
    cyc(0, 0, 1, 32'hFFFFFFFC);
    cyc(0, 0, 0, 0);
    chk("wrap_ifpc", bus.if_id_pc, 32'hFFFFFFFC);
    chk("wrap_plus4", bus.if_id_pc_plus4, 32'h0);
    chk("wrap_pc", bus.pc_out, 32'h0);
    // 6: counter saturation, then reset beats redirect
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
    chk("sat_count", {28'b0, bus.fetch_count}, 32'hF);
    cyc(1, 0, 1, 32'h100);
    chk("rst_redir_pc", bus.pc_out, 32'h0);
    chk("rst_redir_count", {28'b0, bus.fetch_count}, 32'h0);
    chk("rst_redir_valid", {31'b0, bus.if_id_valid}, 32'h0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFFFFF0 | (t & 32'hF);
      if ($urandom_range(0, 2) != 0) t = t & ~32'h3;
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, t);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
